// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// Handles byte/halfword/word loads with sign or zero extension and
// sub-word stores via read-modify-write. Misaligned or illegal-size
// requests complete with resp_err and never touch memory.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | req_ready=1, waiting for req_valid
// RD     | load: MemRead=1, mem_rdata captured at the closing edge
// RMW_RD | sub-word store: MemRead=1, old word captured for merge
// WR     | store: MemWrite=1 with full or merged word on mem_wdata
// RESP   | resp_valid=1, resp_err=0, load result on resp_rdata
// ERR    | resp_valid=1, resp_err=1, resp_rdata=0
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;   // only the low halfword is ever merged

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] r;
        r = w;
        if (size == 2'b00)
            r[{off, 3'b000} +: 8] = wd[7:0];
        else if (off[1])
            r[31:16] = wd;
        else
            r[15:0] = wd;
        return r;
    endfunction

    // Sequencer with registered outputs; reset drops strobes at once and abandons any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'd0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'd0;
            lat_wdata    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= req_addr[1:0];
                        lat_wdata    <= req_wdata[15:0];
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            // mem_addr/mem_wdata keep their old values on errors
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            mem_addr <= {2'b00, req_addr[31:2]};
                            if (!req_we) begin
                                state   <= RD;
                                MemRead <= 1'b1;
                            end else if (req_size == 2'b10) begin
                                state     <= WR;
                                MemWrite  <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                state   <= RMW_RD;
                                MemRead <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    MemRead    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_ext(mem_rdata, lat_off, lat_size, lat_unsigned);
                    state      <= RESP;
                end
                RMW_RD: begin
                    MemRead   <= 1'b0;
                    MemWrite  <= 1'b1;
                    mem_wdata <= store_merge(mem_rdata, lat_off, lat_size, lat_wdata);
                    state     <= WR;
                end
                WR: begin
                    MemWrite   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'd0;
                    state      <= RESP;
                end
                RESP, ERR: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    MemRead    <= 1'b0;
                    MemWrite   <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus reset and back-to-back sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];

    // Word-indexed memory; strobes sampled on the falling edge, read wins over write.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4] = 32'h0000_0007;
        mem[5] = 32'h7FFF_FFFF;
        mem[6] = 32'h8000_0000;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (MemRead)
                mem_rdata = mem[mem_addr[7:0]];
            else if (MemWrite)
                mem[mem_addr[7:0]] = mem_wdata;
        end
    end

    int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, both_cnt = 0;
    logic [31:0] last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0, last_resp_data = 0;

    // Free-running strobe/response monitor.
    always @(negedge clk) begin
        if (MemRead) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_addr;
        end
        if (MemWrite) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
        if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
        if (resp_valid) begin
            resp_cnt       <= resp_cnt + 1;
            last_resp_data <= resp_rdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        logic [31:0] maddr;
        logic [31:0] ewdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input int lat,
                                input logic err, input logic [31:0] rd, input int nrd,
                                input int nwr, input logic [31:0] ma, input logic [31:0] ew);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.lat = lat;
        v.err = err; v.rdata = rd; v.nrd = nrd; v.nwr = nwr; v.maddr = ma; v.ewdata = ew;
        return v;
    endfunction

    task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    endtask

    task automatic do_req(input vec_t v, input int idx);
        int   rd0, wr0, lat;
        logic got, r_err;
        logic [31:0] r_data;
        set_req(v.we, v.size, v.uns, v.addr, v.wdata);
        req_valid = 1'b1;
        rd0 = rd_cnt; wr0 = wr_cnt;
        got = 1'b0; lat = -1; r_err = 1'bx; r_data = 32'hx;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; lat = c; r_err = resp_err; r_data = resp_rdata;
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d resp_err", idx), {31'd0, r_err}, {31'd0, v.err});
        chk($sformatf("v%0d resp_rdata", idx), r_data, v.rdata);
        chk($sformatf("v%0d MemRead cycles", idx), 32'(rd_cnt - rd0), 32'(v.nrd));
        chk($sformatf("v%0d MemWrite cycles", idx), 32'(wr_cnt - wr0), 32'(v.nwr));
        if (v.nrd > 0) chk($sformatf("v%0d read mem_addr", idx), last_rd_addr, v.maddr);
        if (v.nwr > 0) begin
            chk($sformatf("v%0d write mem_addr", idx), last_wr_addr, v.maddr);
            chk($sformatf("v%0d mem_wdata", idx), last_wr_data, v.ewdata);
        end
    endtask

    vec_t vecs[20];
    int   p0, r0, w0;

    initial begin
        vecs[0]  = mk(0, 2'b00, 0, 32'h1B, 0,            2, 0, 32'hFFFF_FF80, 1, 0, 6, 0);
        vecs[1]  = mk(0, 2'b00, 1, 32'h1B, 0,            2, 0, 32'h0000_0080, 1, 0, 6, 0);
        vecs[2]  = mk(0, 2'b01, 0, 32'h16, 0,            2, 0, 32'h0000_7FFF, 1, 0, 5, 0);
        vecs[3]  = mk(0, 2'b01, 0, 32'h14, 0,            2, 0, 32'hFFFF_FFFF, 1, 0, 5, 0);
        vecs[4]  = mk(1, 2'b00, 0, 32'h11, 32'hFFFF_FFAB, 3, 0, 32'h0,       1, 1, 4, 32'h0000_AB07);
        vecs[5]  = mk(0, 2'b10, 0, 32'h10, 0,            2, 0, 32'h0000_AB07, 1, 0, 4, 0);
        vecs[6]  = mk(0, 2'b10, 0, 32'h06, 0,            1, 1, 32'h0,        0, 0, 0, 0);
        vecs[7]  = mk(0, 2'b11, 0, 32'h10, 0,            1, 1, 32'h0,        0, 0, 0, 0);
        vecs[8]  = mk(1, 2'b10, 0, 32'h20, 32'h1234_5678, 2, 0, 32'h0,       0, 1, 8, 32'h1234_5678);
        vecs[9]  = mk(0, 2'b10, 0, 32'h20, 0,            2, 0, 32'h1234_5678, 1, 0, 8, 0);
        vecs[10] = mk(0, 2'b01, 1, 32'h22, 0,            2, 0, 32'h0000_1234, 1, 0, 8, 0);
        vecs[11] = mk(0, 2'b00, 0, 32'h21, 0,            2, 0, 32'h0000_0056, 1, 0, 8, 0);
        vecs[12] = mk(0, 2'b01, 0, 32'h20, 0,            2, 0, 32'h0000_5678, 1, 0, 8, 0);
        vecs[13] = mk(1, 2'b01, 0, 32'h22, 32'h1111_BEEF, 3, 0, 32'h0,       1, 1, 8, 32'hBEEF_5678);
        vecs[14] = mk(0, 2'b10, 0, 32'h20, 0,            2, 0, 32'hBEEF_5678, 1, 0, 8, 0);
        vecs[15] = mk(0, 2'b01, 0, 32'h22, 0,            2, 0, 32'hFFFF_BEEF, 1, 0, 8, 0);
        vecs[16] = mk(0, 2'b00, 1, 32'h23, 0,            2, 0, 32'h0000_00BE, 1, 0, 8, 0);
        vecs[17] = mk(0, 2'b01, 0, 32'h21, 0,            1, 1, 32'h0,        0, 0, 0, 0);
        vecs[18] = mk(1, 2'b01, 0, 32'h23, 32'h5555,     1, 1, 32'h0,        0, 0, 0, 0);
        vecs[19] = mk(1, 2'b10, 0, 32'h22, 32'hDEAD_BEEF, 1, 1, 32'h0,       0, 0, 0, 0);

        rst = 1'b1;
        req_valid = 1'b0;
        set_req(0, 2'b00, 0, 32'd0, 32'd0);

        // reset values before any clock edge
        #3;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) do_req(vecs[i], i);

        chk("mem word1 after errors", mem[1], 32'd0);
        chk("mem word4 after errors", mem[4], 32'h0000_AB07);
        chk("mem word8 after errors", mem[8], 32'hBEEF_5678);

        // reset during RMW_RD of sh 0x1234 to 0x12
        set_req(1, 2'b01, 0, 32'h12, 32'h0000_1234);
        req_valid = 1'b1;
        w0 = wr_cnt; p0 = resp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rmw MemRead before rst", {31'd0, MemRead}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rmw MemRead on rst", {31'd0, MemRead}, 32'd0);
        chk("rmw MemWrite on rst", {31'd0, MemWrite}, 32'd0);
        chk("rmw req_ready on rst", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rmw no write", 32'(wr_cnt - w0), 32'd0);
        chk("rmw no response", 32'(resp_cnt - p0), 32'd0);
        chk("rmw word4 unchanged", mem[4], 32'h0000_AB07);

        // first request right after reset release
        do_req(mk(0, 2'b10, 0, 32'h10, 0, 2, 0, 32'h0000_AB07, 1, 0, 4, 0), 100);

        // req_valid held high with loads: accepts on edges 1, 4, 7 of the window
        set_req(0, 2'b10, 0, 32'h10, 0);
        req_valid = 1'b1;
        p0 = resp_cnt; r0 = rd_cnt;
        repeat (9) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b load responses", 32'(resp_cnt - p0), 32'd3);
        chk("b2b load reads", 32'(rd_cnt - r0), 32'd3);
        chk("b2b load data", last_resp_data, 32'h0000_AB07);

        // req_valid held high with byte stores: accepts on edges 1 and 5 of the window
        set_req(1, 2'b00, 0, 32'h25, 32'h0000_005A);
        req_valid = 1'b1;
        p0 = resp_cnt; r0 = rd_cnt; w0 = wr_cnt;
        repeat (8) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b store responses", 32'(resp_cnt - p0), 32'd2);
        chk("b2b store reads", 32'(rd_cnt - r0), 32'd2);
        chk("b2b store writes", 32'(wr_cnt - w0), 32'd2);
        chk("b2b store word9", mem[9], 32'h0000_5A00);
        chk("strobe overlap cycles", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
